regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor of the core register file: DEPTH = 2^ADDR_W registers, each DATA_W wide, with two asynchronous read ports and one synchronous write port.
- Synchronous active-low reset clears the whole array.
- Optional hard-wired zero register and optional write-to-read bypass.
- Pending-write scoreboard: the decode stage marks destinations on issue, writeback clears them, and the pipeline uses the busy flags for hazard stalls.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst_n, input, 1, synchronous active-low reset, sampled on posedge clk.
- r_add1, input, ADDR_W, read port 1 address.
- r_add2, input, ADDR_W, read port 2 address.
- read1, output, DATA_W, read port 1 data (combinational).
- read2, output, DATA_W, read port 2 data (combinational).
- wr_en, input, 1, writeback enable.
- wr_add, input, ADDR_W, writeback address.
- datain, input, DATA_W, writeback data.
- iss_en, input, 1, issue: mark iss_add as pending.
- iss_add, input, ADDR_W, destination being issued.
- busy1, output, 1, source 1 has an outstanding write.
- busy2, output, 1, source 2 has an outstanding write.
- pend_cnt, output, ADDR_W+1, number of pending registers.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low (fixed).
- Reset:
  - rst_n=0 at a posedge sets all registers to 0, all pending bits to 0, and pend_cnt to 0, in one cycle.
  - wr_en and iss_en are ignored during that cycle.
  - Outputs after reset: read1 = read2 = 0 (absent bypass), busy1 = busy2 = 0, pend_cnt = 0.
  - Reset mid-operation discards all outstanding pending bits.
- Write:
  - On posedge with rst_n=1 and wr_en=1, reg[wr_add] <= datain.
  - If ZERO_REG=1 and wr_add=0, there is no effect.
- Read:
  - readN = reg[r_addN] combinationally.
  - If ZERO_REG=1 and r_addN=0, readN = 0.
  - If BYPASS=1, wr_en=1, wr_add=r_addN and the write is effective, then readN = datain (zero latency).
  - If BYPASS=0, the new value is visible the cycle after the write.
- Scoreboard, updated on posedge with rst_n=1:
  - iss_en=1 sets pend[iss_add].
  - wr_en=1 clears pend[wr_add].
  - Same address in the same cycle: set wins (a new writer issued while the old one retires), so the bit stays 1.
  - ZERO_REG=1: pend[0] is held at 0 and issue/write to address 0 is ignored by the scoreboard.
  - Writeback to a non-pending register is legal; it updates data only.
  - Issue to an already pending register is legal; the bit stays 1.
- busyN:
  - busyN = pend[r_addN], except forced 0 when BYPASS=1, wr_en=1 and wr_add=r_addN (data is forwarded this cycle).
  - Issue in the current cycle does not affect busyN until the next cycle.
- pend_cnt:
  - Registered; always equals popcount(pend).
  - Next value = pend_cnt + inc − dec.
  - inc = iss_en effective and pend[iss_add]=0.
  - dec = wr_en effective, pend[wr_add]=1, and not (iss_en effective and iss_add=wr_add).
  - Range 0..DEPTH; it can never over/underflow because the increment/decrement are gated on the actual bit transitions.

Test Plan:
1. Reset then reads: rst_n=0 for 1 cycle after the array is loaded with 0xFFFFFFFF → read1/read2 = 0 for all addresses; busy = 0; pend_cnt = 0.
2. Zero register: wr_en=1, wr_add=0, datain=0xDEADBEEF; iss_en=1, iss_add=0 → read1 at r_add1=0 = 0; busy1 = 0; pend_cnt = 0.
3. Bypass:
   - BYPASS=1: wr_add=5, datain=0x12345678, r_add1=5, reg[5] previously 0xA → read1 = 0x12345678 in the same cycle.
   - BYPASS=0: same stimulus → read1 = 0xA, then 0x12345678 the next cycle.
4. Scoreboard life cycle: issue 3, then 7 → pend_cnt 1, then 2; r_add2=7 → busy2=1. Writeback 7 (BYPASS=1) → busy2=0 the same cycle, pend_cnt=1 next cycle. Writeback 3 → pend_cnt=0.
5. Simultaneous same address: pend[9]=1, iss_add=9 and wr_add=9 in the same cycle → pend[9] stays 1, pend_cnt unchanged, reg[9]=datain. Non-pending writeback to 4 → pend_cnt unchanged.
6. Reset mid-operation with pend_cnt=6 → next cycle pend_cnt=0, all busy = 0, all registers 0; a concurrent wr_en is ignored.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: register file bus; master drives read/write/issue addresses and data, slave returns read data, busy flags and pend_cnt
interface regfile_sb_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] r_add1, r_add2, wr_add, iss_add;
  logic [DATA_W-1:0] read1, read2, datain;
  logic wr_en, iss_en, busy1, busy2;
  logic [ADDR_W:0] pend_cnt;
  modport master (output r_add1, r_add2, wr_en, wr_add, datain, iss_en, iss_add,
                  input read1, read2, busy1, busy2, pend_cnt);
  modport slave (input r_add1, r_add2, wr_en, wr_add, datain, iss_en, iss_add,
                 output read1, read2, busy1, busy2, pend_cnt);
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R1W register file with pending-write scoreboard; clk, rst_n (sync active-low), bus = regfile_sb_if.slave
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst_n,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic wr_ok, iss_ok, inc, dec, fwd1, fwd2;
  assign wr_ok = bus.wr_en && !(ZERO_REG != 0 && bus.wr_add == '0);
  assign iss_ok = bus.iss_en && !(ZERO_REG != 0 && bus.iss_add == '0);
  assign fwd1 = BYPASS != 0 && wr_ok && bus.wr_add == bus.r_add1;
  assign fwd2 = BYPASS != 0 && wr_ok && bus.wr_add == bus.r_add2;
  assign bus.read1 = (ZERO_REG != 0 && bus.r_add1 == '0) ? '0 : fwd1 ? bus.datain : mem_q[bus.r_add1];
  assign bus.read2 = (ZERO_REG != 0 && bus.r_add2 == '0) ? '0 : fwd2 ? bus.datain : mem_q[bus.r_add2];
  assign bus.busy1 = pend_q[bus.r_add1] && !fwd1;
  assign bus.busy2 = pend_q[bus.r_add2] && !fwd2;
  assign bus.pend_cnt = cnt_q;
  assign inc = iss_ok && !pend_q[bus.iss_add];
  assign dec = wr_ok && pend_q[bus.wr_add] && !(iss_ok && bus.iss_add == bus.wr_add);
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) pend_d[bus.wr_add] = 1'b0;
    if (iss_ok) pend_d[bus.iss_add] = 1'b1;
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok) mem_q[bus.wr_add] <= bus.datain;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb, bypass and non-bypass instances side by side
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ia ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ib ();
  assign ib.r_add1 = ia.r_add1;
  assign ib.r_add2 = ia.r_add2;
  assign ib.wr_en = ia.wr_en;
  assign ib.wr_add = ia.wr_add;
  assign ib.datain = ia.datain;
  assign ib.iss_en = ia.iss_en;
  assign ib.iss_add = ia.iss_add;
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    ia.wr_en = 1'b0;
    ia.iss_en = 1'b0;
  endtask
  initial begin
    ia.r_add1 = '0;
    ia.r_add2 = '0;
    ia.wr_add = '0;
    ia.iss_add = '0;
    ia.datain = '0;
    idle();
    tick();
    rst_n = 1'b1;
    for (int a = 1; a < 32; a++) begin
      ia.wr_en = 1'b1;
      ia.wr_add = 5'(a);
      ia.datain = 32'hFFFF_FFFF;
      tick();
    end
    idle();
    ia.iss_en = 1'b1;
    ia.iss_add = 5'd10;
    tick();
    ia.iss_add = 5'd11;
    tick();
    idle();
    ia.r_add1 = 5'd5;
    ia.r_add2 = 5'd11;
    #1;
    chk("preload_read", ia.read1, 32'hFFFF_FFFF);
    chk("preload_busy", ia.busy2, 1'b1);
    chk("preload_cnt", ia.pend_cnt, 6'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ia.r_add1 = 5'(a);
      ia.r_add2 = 5'(31 - a);
      #1;
      chk("rst_read1_a", ia.read1, 32'h0);
      chk("rst_read2_a", ia.read2, 32'h0);
      chk("rst_read1_b", ib.read1, 32'h0);
      chk("rst_busy", {ia.busy1, ia.busy2, ib.busy1, ib.busy2}, 4'h0);
    end
    chk("rst_cnt", ia.pend_cnt, 6'd0);
    ia.wr_en = 1'b1;
    ia.wr_add = 5'd0;
    ia.datain = 32'hDEAD_BEEF;
    ia.iss_en = 1'b1;
    ia.iss_add = 5'd0;
    ia.r_add1 = 5'd0;
    #1;
    chk("zero_read_same", ia.read1, 32'h0);
    chk("zero_busy_same", ia.busy1, 1'b0);
    tick();
    idle();
    #1;
    chk("zero_read_next", ia.read1, 32'h0);
    chk("zero_read_next_b", ib.read1, 32'h0);
    chk("zero_busy_next", ia.busy1, 1'b0);
    chk("zero_cnt", ia.pend_cnt, 6'd0);
    ia.wr_en = 1'b1;
    ia.wr_add = 5'd5;
    ia.datain = 32'hA;
    tick();
    ia.datain = 32'h1234_5678;
    ia.r_add1 = 5'd5;
    #1;
    chk("bypass_on_same", ia.read1, 32'h1234_5678);
    chk("bypass_off_same", ib.read1, 32'hA);
    tick();
    idle();
    #1;
    chk("bypass_on_next", ia.read1, 32'h1234_5678);
    chk("bypass_off_next", ib.read1, 32'h1234_5678);
    ia.iss_en = 1'b1;
    ia.iss_add = 5'd3;
    tick();
    chk("sb_cnt_iss3", ia.pend_cnt, 6'd1);
    ia.iss_add = 5'd7;
    tick();
    idle();
    ia.r_add2 = 5'd7;
    ia.r_add1 = 5'd3;
    #1;
    chk("sb_cnt_iss7", ia.pend_cnt, 6'd2);
    chk("sb_busy2", ia.busy2, 1'b1);
    chk("sb_busy1", ia.busy1, 1'b1);
    ia.wr_en = 1'b1;
    ia.wr_add = 5'd7;
    ia.datain = 32'h77;
    #1;
    chk("sb_wb7_busy2_a", ia.busy2, 1'b0);
    chk("sb_wb7_busy2_b", ib.busy2, 1'b1);
    chk("sb_wb7_read2_a", ia.read2, 32'h77);
    tick();
    idle();
    #1;
    chk("sb_wb7_cnt", ia.pend_cnt, 6'd1);
    chk("sb_wb7_busy2_next", ib.busy2, 1'b0);
    chk("sb_wb7_read2_b", ib.read2, 32'h77);
    ia.wr_en = 1'b1;
    ia.wr_add = 5'd3;
    ia.datain = 32'h33;
    tick();
    idle();
    #1;
    chk("sb_wb3_cnt", ia.pend_cnt, 6'd0);
    chk("sb_wb3_busy1", ia.busy1, 1'b0);
    ia.iss_en = 1'b1;
    ia.iss_add = 5'd9;
    tick();
    chk("same_pre_cnt", ia.pend_cnt, 6'd1);
    ia.wr_en = 1'b1;
    ia.wr_add = 5'd9;
    ia.datain = 32'h99;
    tick();
    idle();
    ia.r_add1 = 5'd9;
    ia.r_add2 = 5'd9;
    #1;
    chk("same_cnt", ia.pend_cnt, 6'd1);
    chk("same_busy2", ia.busy2, 1'b1);
    chk("same_data", ia.read1, 32'h99);
    ia.wr_en = 1'b1;
    ia.wr_add = 5'd4;
    ia.datain = 32'h44;
    tick();
    idle();
    ia.r_add1 = 5'd4;
    #1;
    chk("nonpend_cnt", ia.pend_cnt, 6'd1);
    chk("nonpend_data", ib.read1, 32'h44);
    ia.iss_en = 1'b1;
    ia.iss_add = 5'd9;
    tick();
    chk("repend_cnt", ia.pend_cnt, 6'd1);
    for (int a = 1; a <= 5; a++) begin
      ia.iss_add = 5'(a);
      tick();
    end
    idle();
    chk("mid_pre_cnt", ia.pend_cnt, 6'd6);
    rst_n = 1'b0;
    ia.wr_en = 1'b1;
    ia.wr_add = 5'd12;
    ia.datain = 32'hCAFE;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    chk("mid_cnt", ia.pend_cnt, 6'd0);
    chk("mid_cnt_b", ib.pend_cnt, 6'd0);
    for (int a = 0; a < 32; a++) begin
      ia.r_add1 = 5'(a);
      ia.r_add2 = 5'(a);
      #1;
      chk("mid_read", {ia.read1, ib.read2}, 64'h0);
      chk("mid_busy", {ia.busy1, ib.busy2}, 2'b00);
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
